// File: rtl/seq_divider_32_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_32_if
// Desc     : Start/operand/result bundle between the controller and divider.
// Revision : 1.0
// ============================================================================
interface seq_divider_32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_divider_32.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_32
// Desc     : Restoring shift-subtract divider, one quotient bit per clock,
//            signed (truncating) or unsigned, fixed latency.
// Revision : 1.0
// ============================================================================
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_divider_32_if.slave  bus
);
    localparam int                c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_busy;
    logic                 w_done;

    logic                 r_signed;
    logic                 r_sign_n;
    logic                 r_sign_d;
    logic                 r_zero;
    logic [WIDTH-1:0]     r_dvs;
    logic [WIDTH-1:0]     r_dividend_raw;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_q;
    logic [c_cnt_w-1:0]   r_count;
    logic [WIDTH-1:0]     r_quotient;
    logic [WIDTH-1:0]     r_remainder;
    logic                 r_dbz;

    logic [WIDTH-1:0]     w_dividend_abs;
    logic [WIDTH-1:0]     w_divisor_abs;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_trial;

    assign w_dividend_abs = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign w_divisor_abs  = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    // The partial remainder stays below the divisor, so WIDTH bits hold it;
    // the extra top bit only exists in the shifted/trial values.
    assign w_shift = {r_rem, r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: if (bus.start) w_next_state = S_CALC;
            S_CALC: begin
                w_busy = 1'b1;
                if (r_count == c_last_iter) w_next_state = S_FIX;
            end
            S_FIX: begin
                w_busy       = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_signed       <= 1'b0;
            r_sign_n       <= 1'b0;
            r_sign_d       <= 1'b0;
            r_zero         <= 1'b0;
            r_dvs          <= '0;
            r_dividend_raw <= '0;
            r_rem          <= '0;
            r_q            <= '0;
            r_count        <= '0;
            r_quotient     <= '0;
            r_remainder    <= '0;
            r_dbz          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_signed       <= bus.is_signed;
                        r_sign_n       <= bus.dividend[WIDTH-1];
                        r_sign_d       <= bus.divisor[WIDTH-1];
                        r_zero         <= (bus.divisor == '0);
                        r_dvs          <= w_divisor_abs;
                        r_dividend_raw <= bus.dividend;
                        r_rem          <= '0;
                        r_q            <= w_dividend_abs;
                        r_count        <= '0;
                        r_dbz          <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_rem   <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_q     <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_count <= r_count + c_cnt_w'(1);
                end
                S_FIX: begin
                    if (r_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dividend_raw;
                        r_dbz       <= 1'b1;
                    end else if (r_signed) begin
                        r_quotient  <= (r_sign_n ^ r_sign_d) ? -r_q : r_q;
                        r_remainder <= r_sign_n ? -r_rem : r_rem;
                    end else begin
                        r_quotient  <= r_q;
                        r_remainder <= r_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider_32
// Desc     : Directed and random operations against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_seq_divider_32;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    seq_divider_32_if #(.WIDTH(32)) bus ();

    seq_divider_32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {div_by_zero, quotient, remainder} from plain integer arithmetic
    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, q[31:0], r[31:0]};
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = s;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        drive(a, b, s);
        bus.start = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_q"},    64'(bus.quotient), 64'd0);
        check({tag, "_r"},    64'(bus.remainder), 64'd0);
        check({tag, "_dbz"},  64'(bus.div_by_zero), 64'd0);
    endtask

    // Ends on the negedge where done is observed. pre=1: start already driven in IDLE.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input bit glitch, input bit pre);
        logic [64:0] e;
        int busy_n;
        int done_at;
        e       = model(a, b, s);
        busy_n  = 0;
        done_at = 0;
        if (!pre) begin
            @(negedge clk);
            issue(a, b, s);
        end
        @(negedge clk);
        bus.start = 1'b0;
        drive($urandom, $urandom, 1'($urandom));
        for (int i = 1; i <= 60 && done_at == 0; i++) begin
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1) begin
                done_at = i;
            end else begin
                bus.start = glitch && (i == 5 || i == 20);
                if (bus.start) drive($urandom, $urandom_range(1, 9), 1'($urandom));
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 64'(done_at), 64'd34);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
        check({tag, "_q"},   64'(bus.quotient),    64'(e[63:32]));
        check({tag, "_r"},   64'(bus.remainder),   64'(e[31:0]));
        check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(e[64]));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [64:0] e;
        bit          saw_done;

        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        drive(32'd0, 32'd0, 1'b0);
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        do_op("u_100_7",     32'd100,          32'd7,          1'b0, 1'b0, 1'b0);
        do_op("s_m7_2",      32'hFFFF_FFF9,    32'd2,          1'b1, 1'b0, 1'b0);
        do_op("s_7_m2",      32'd7,            32'hFFFF_FFFE,  1'b1, 1'b0, 1'b0);
        do_op("s_dbz",       32'h1234_5678,    32'd0,          1'b1, 1'b0, 1'b0);
        do_op("u_dbz",       32'h1234_5678,    32'd0,          1'b0, 1'b0, 1'b0);
        do_op("s_ovf",       32'h8000_0000,    32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0);
        do_op("u_max_1",     32'hFFFF_FFFF,    32'd1,          1'b0, 1'b0, 1'b0);
        do_op("s_min_m7",    32'h8000_0000,    32'hFFFF_FFF9,  1'b1, 1'b0, 1'b0);
        do_op("glitch",      32'd1000,         32'd33,         1'b0, 1'b1, 1'b0);

        // Start raised in the DONE cycle must be ignored; held into IDLE it is taken.
        do_op("coinc_a",     32'hFFFF_FF00,    32'd17,         1'b1, 1'b0, 1'b0);
        e = model(32'hFFFF_FF00, 32'd17, 1'b1);
        issue(32'hDEAD_BEEF, 32'd12345, 1'b0);
        @(negedge clk);
        check("coinc_done_pulse", 64'(bus.done), 64'd0);
        check("coinc_ignored",    64'(bus.busy), 64'd0);
        check("coinc_hold_q",     64'(bus.quotient), 64'(e[63:32]));
        do_op("coinc_b",     32'hDEAD_BEEF,    32'd12345,      1'b0, 1'b0, 1'b1);

        // Leave a nonzero result with the flag set, then reset in the middle of CALC.
        do_op("pre_rst",     32'h1234_5678,    32'd0,          1'b0, 1'b0, 1'b0);
        @(negedge clk);
        issue(32'd100, 32'd7, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("no_done_after_reset", 64'(saw_done), 64'd0);
        do_op("after_rst",   32'd100,          32'd7,          1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            a = $urandom;
            s = 1'($urandom);
            case (k % 4)
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 300));
                2:       b = 32'd0 - 32'($urandom_range(1, 300));
                default: b = a >> $urandom_range(0, 31);
            endcase
            do_op($sformatf("rand%0d", k), a, b, s, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
